// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t : loader FSM states
//   CNT_W   : width of the big-endian word-count field
//   BYTE_W  : width of one stream byte
package imem_boot_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs stream bytes, MSB first, into 32-bit words and keeps a running XOR
// checksum of every byte it is given.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the byte counter and checksum (word register kept)
//   byte_en   : byte_in is accepted on this edge
//   byte_in   : payload byte
//   word_out  : assembled word (valid the cycle after word_full)
//   word_full : the byte being accepted now completes a word
//   csum      : XOR of all accepted bytes since reset/clear
module boot_word_assembler
  import imem_boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [31:0]       word_out,
  output logic              word_full,
  output logic [BYTE_W-1:0] csum
);

  logic [31:0]       word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    csum_d = csum_q;
    if (clear) begin
      cnt_d  = '0;
      csum_d = '0;
    end else if (byte_en) begin
      word_d = {word_q[31-BYTE_W:0], byte_in};
      cnt_d  = cnt_q + 2'd1;  // wraps 3 -> 0
      csum_d = csum_q ^ byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      csum_q <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      csum_q <= csum_d;
    end
  end

  assign word_out  = word_q;
  assign word_full = byte_en && (cnt_q == 2'd3);
  assign csum      = csum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a checksummed instruction image from a byte stream into instruction
// memory and holds the CPU in reset until the image is verified.
// Frame: count_hi, count_lo, N*4 payload bytes (MSB first), XOR checksum.
//   clk, rst           : clock, synchronous active-high reset
//   reload             : restart loading (only from done/error)
//   in_valid, in_data  : byte stream; in_ready back-pressure
//   im_we, im_addr,
//   im_wdata           : instruction-memory write port (word addressed)
//   cpu_rst            : processor reset, low only once an image is verified
//   done, error        : load outcome
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(2**ADDR_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              im_we_q, im_we_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic [CNT_W-1:0]  n_full;
  logic              last_word;
  logic              asm_clear;
  logic              asm_byte_en;
  logic [31:0]       asm_word;
  logic              asm_full;
  logic [BYTE_W-1:0] asm_csum;

  assign xfer   = in_valid && in_ready_q;
  assign n_full = {cnt_q[CNT_W-1:BYTE_W], in_data};
  // Index is one bit wider than im_addr so N == MAX_WORDS terminates cleanly.
  assign last_word = ((CNT_W+1)'(idx_q) + (CNT_W+1)'(1)) == {1'b0, cnt_q};

  boot_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .byte_en   (asm_byte_en),
    .byte_in   (in_data),
    .word_out  (asm_word),
    .word_full (asm_full),
    .csum      (asm_csum)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    asm_clear   = 1'b0;
    asm_byte_en = 1'b0;
    unique case (state_q)
      S_CNT_HI: begin
        if (xfer) begin
          cnt_d   = {in_data, cnt_q[BYTE_W-1:0]};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          cnt_d = n_full;
          if ({1'b0, n_full} > MAX_WORDS) state_d = S_ERR;
          else if (n_full == '0)          state_d = S_CSUM;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        asm_byte_en = xfer;
        if (asm_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = idx_q + (ADDR_W+1)'(1);
        state_d = last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) state_d = (in_data == asm_csum) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d   = S_CNT_HI;
          asm_clear = 1'b1;
          idx_d     = '0;
        end
      end
      default: state_d = S_CNT_HI;
    endcase

    // Outputs are registered: decode them from the next state.
    in_ready_d = state_d inside {S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM};
    im_we_d    = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_rst_d  = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CNT_HI;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = idx_q[ADDR_W-1:0];
  assign im_wdata = asm_word;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic        mon_en = 1'b0;
  logic        exp_we = 1'b0;
  logic [7:0]  fr[$];
  logic [7:0]  cap_addr[$];
  logic [31:0] cap_data[$];

  imem_boot_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .reload   (reload),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: strobe timing, back-pressure during writes, capture.
  always @(negedge clk) begin
    if (mon_en) begin
      check("im_we_timing", {63'd0, im_we}, {63'd0, exp_we});
      if (im_we) begin
        check("ready_low_in_write", {63'd0, in_ready}, 64'd0);
        cap_addr.push_back(im_addr);
        cap_data.push_back(im_wdata);
      end
    end
  end

  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0] b;
    logic [7:0] cs;
    fr.delete();
    fr.push_back(8'((n >> 8) & 255));
    fr.push_back(8'(n & 255));
    cs = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      fr.push_back(b);
      cs = cs ^ b;
    end
    fr.push_back(corrupt ? (cs ^ 8'($urandom_range(1, 255))) : cs);
  endtask

  // Reference: decode the frame directly, drive it, then compare outcome.
  task automatic run_frame(input bit stall, input bit noise);
    int          n, len, k, cycles;
    bit          ok, oversize, acc;
    logic [7:0]  cs;
    logic [31:0] w;
    logic [31:0] exp_words[$];
    n        = int'(fr[0]) * 256 + int'(fr[1]);
    oversize = (n > 256);
    exp_words.delete();
    cs = 8'h00;
    ok = 1'b0;
    if (oversize) begin
      len = 2;
    end else begin
      len = 2 + 4 * n + 1;
      for (int i = 0; i < n; i++) begin
        w = {fr[2+4*i], fr[3+4*i], fr[4+4*i], fr[5+4*i]};
        exp_words.push_back(w);
        cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      end
      ok = (fr[2+4*n] == cs);
    end

    cap_addr.delete();
    cap_data.delete();
    mon_en = 1'b1;
    k = 0;
    cycles = 0;
    while (k < len && cycles < 5000) begin
      @(negedge clk);
      in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? fr[k] : 8'($urandom_range(0, 255));
      reload   = noise && ($urandom_range(0, 7) == 0);
      acc      = in_valid && in_ready;
      @(posedge clk);
      #1;
      exp_we = acc && !oversize && (k >= 2) && (k < 2 + 4 * n) && (((k - 2) % 4) == 3);
      if (acc) k++;
      cycles++;
    end
    if (cycles >= 5000) check("frame_timeout", 64'(k), 64'(len));
    @(negedge clk);
    in_valid = 1'b0;
    reload   = 1'b0;
    @(negedge clk);
    check("done",     {63'd0, done},     {63'd0, ok});
    check("error",    {63'd0, error},    {63'd0, !ok});
    check("cpu_rst",  {63'd0, cpu_rst},  {63'd0, !ok});
    check("ready_end", {63'd0, in_ready}, 64'd0);
    check("num_writes", 64'(cap_data.size()), 64'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < cap_data.size(); i++) begin
      check("wr_addr", 64'(cap_addr[i]), 64'(i % 256));
      check("wr_data", 64'(cap_data[i]), 64'(exp_words[i]));
    end
    // Bytes offered after the frame must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_accept_after", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    mon_en   = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_cpu_rst", {63'd0, cpu_rst},  64'd1);
    check("reload_done",    {63'd0, done},     64'd0);
    check("reload_error",   {63'd0, error},    64'd0);
    check("reload_ready",   {63'd0, in_ready}, 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   {63'd0, in_ready}, 64'd0);
    check({tag, "_we"},      {63'd0, im_we},    64'd0);
    check({tag, "_addr"},    64'(im_addr),      64'd0);
    check({tag, "_wdata"},   64'(im_wdata),     64'd0);
    check({tag, "_cpu_rst"}, {63'd0, cpu_rst},  64'd1);
    check({tag, "_done"},    {63'd0, done},     64'd0);
    check({tag, "_error"},   {63'd0, error},    64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Nominal image.
    fr = '{8'h00, 8'h02, 8'h01, 8'h4A, 8'h48, 8'h20, 8'h01, 8'h09, 8'h50, 8'h22, 8'h59};
    run_frame(1'b0, 1'b0);
    do_reload();

    // Bad checksum.
    fr = '{8'h00, 8'h02, 8'h01, 8'h4A, 8'h48, 8'h20, 8'h01, 8'h09, 8'h50, 8'h22, 8'h58};
    run_frame(1'b0, 1'b0);
    do_reload();

    // Zero count.
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0, 1'b0);
    do_reload();

    // Oversize count (257 > 256).
    fr = '{8'h01, 8'h01};
    run_frame(1'b0, 1'b0);
    do_reload();

    // Nominal image with stalls and ignored reload requests.
    fr = '{8'h00, 8'h02, 8'h01, 8'h4A, 8'h48, 8'h20, 8'h01, 8'h09, 8'h50, 8'h22, 8'h59};
    run_frame(1'b1, 1'b1);
    do_reload();

    // Reload image.
    fr = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    run_frame(1'b0, 1'b0);
    do_reload();

    // Full capacity: N == MAX_WORDS.
    build_frame(256, 1'b0);
    run_frame(1'b1, 1'b0);
    do_reload();

    // Random frames.
    for (int t = 0; t < 6; t++) begin
      build_frame($urandom_range(0, 6), ($urandom_range(0, 2) == 0));
      run_frame(1'b1, 1'b1);
      do_reload();
    end

    // Reset part-way through a word, then a fresh frame.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    in_data  = 8'h01;
    @(negedge clk);
    in_data  = 8'h11;
    @(negedge clk);
    in_data  = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check_reset_vals("midload_rst");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", {63'd0, in_ready}, 64'd1);
    build_frame(3, 1'b0);
    run_frame(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
